// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the programmable sequence detector and its bench.
//   SEQ_MAX_LEN : default maximum pattern length
//   LEN_W       : width of a pattern-length field for the default maximum
//   len_legal() : true when a requested pattern length is usable (2..max)
package seq_det_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int LEN_W       = $clog2(SEQ_MAX_LEN + 1);

    function automatic logic len_legal(input int unsigned len, input int unsigned max);
        return (len >= 2) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt
//   Generic saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-high (count -> 0)
//   clr   : synchronous clear, has priority over inc
//   inc   : increment by one, holding at all-ones once saturated
//   count : current count value
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Run-time programmable Mealy serial-pattern detector.
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active-high
//   in_valid  : qualifies in_seq; history advances only when high
//   in_seq    : serial data bit
//   cfg_load  : one-cycle strobe loading cfg_pat/cfg_len/cfg_ovl
//   cfg_pat   : pattern, right-aligned, bit cfg_len-1 received first
//   cfg_len   : pattern length, legal 2..MAX_LEN
//   cfg_ovl   : 1 = overlapping detection
//   det_out   : combinational detect on the final pattern bit
//   det_count : saturating detection count
//   cfg_err   : one-cycle pulse after a cfg_load with illegal cfg_len
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int                   MAX_LEN = 8,
    parameter int                   CNT_W   = 8,
    parameter logic [MAX_LEN-1:0]   RST_PAT = 8'b0011_1010,
    parameter int                   RST_LEN = 6,
    parameter logic                 RST_OVL = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_seq,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pat,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_ovl,
    output logic                           det_out,
    output logic [CNT_W-1:0]               det_count,
    output logic                           cfg_err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LW:0]        fill_p1;
    logic               fill_ok;
    logic               cfg_ok;
    logic               match;

    // The newest bit is appended below the history; the same vector is the
    // shifted history for the next cycle once its top bit is dropped.
    assign window  = {hist, in_seq};
    assign fill_p1 = {1'b0, fill} + {{LW{1'b0}}, 1'b1};
    assign fill_ok = (fill_p1 >= {1'b0, len});
    assign cfg_ok  = len_legal(int'(cfg_len), MAX_LEN);

    // Only the low len bits take part in the compare; pattern bits above
    // len-1 are don't-care.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // A cfg_load cycle swallows the same-cycle input, legal or not.
    assign match   = in_valid && !cfg_load && fill_ok && (((window ^ pat) & mask) == '0);
    assign det_out = match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= RST_PAT;
            len     <= LW'(RST_LEN);
            ovl     <= RST_OVL;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat  <= cfg_pat;
                    len  <= cfg_len;
                    ovl  <= cfg_ovl;
                    hist <= '0;
                    fill <= '0;
                end
            end else if (in_valid) begin
                if (match && !ovl) begin
                    // Non-overlapping: the next match must be built from fresh bits.
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[MAX_LEN-2:0];
                    if (fill != LW'(MAX_LEN - 1)) begin
                        fill <= fill + LW'(1);
                    end
                end
            end
        end
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cfg_load && cfg_ok),
        .inc   (match),
        .count (det_count)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
//   Directed-vector bench for seq_detect_prog. A second instance with a
//   2-bit counter shares all inputs and is examined for saturation.
module tb_seq_detect_prog;
    import seq_det_pkg::*;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_seq;
    logic             cfg_load;
    logic [7:0]       cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             det_out;
    logic [7:0]       det_count;
    logic             cfg_err;
    logic             det_out2;
    logic [1:0]       det_count2;
    logic             cfg_err2;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_prog dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .det_out(det_out), .det_count(det_count), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .det_out(det_out2), .det_count(det_count2), .cfg_err(cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Entered at posedge+1; samples at the falling edge; leaves at posedge+1.
    task automatic send_bit(input logic v, input logic b, input logic exp_det, input string tag);
        in_valid = v;
        in_seq   = b;
        #4;
        check(tag, det_out, exp_det);
        @(posedge clk); #1;
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n, input logic [15:0] exp, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(1'b1, bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o,
                            input logic exp_err, input string tag);
        cfg_load = 1'b1;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        in_valid = 1'b1;
        in_seq   = 1'b1;
        #4;
        check({tag, "_det_blocked"}, det_out, 1'b0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        #4;
        check({tag, "_err"}, cfg_err, exp_err);
        @(posedge clk); #1;
        #4;
        check({tag, "_err_clr"}, cfg_err, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_seq = 1'b0;
        cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_det", det_out, 1'b0);
        check("rst_cnt", det_count, 8'd0);
        check("rst_err", cfg_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Default pattern 111010, non-overlapping
        send_stream(16'b1110_1011_1010, 12, 16'b0000_0100_0001, "def");
        check("def_cnt", det_count, 8'd2);

        // 1010 overlapping
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, "ld1010o");
        check("ld1010o_cnt", det_count, 8'd0);
        send_stream(16'b101_0101, 7, 16'b000_1010, "p1010o");
        check("p1010o_cnt", det_count, 8'd2);

        // 1010 non-overlapping
        load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, "ld1010n");
        send_stream(16'b101_0101, 7, 16'b000_1000, "p1010n");
        check("p1010n_cnt", det_count, 8'd1);

        // Gaps in in_valid hold history
        load_cfg(8'b0011_1010, 4'd6, 1'b0, 1'b0, "ldgap");
        send_stream(16'b1110, 4, 16'b0000, "gap_a");
        for (int i = 0; i < 3; i++) send_bit(1'b0, i[0], 1'b0, $sformatf("gap_idle%0d", i));
        send_stream(16'b10, 2, 16'b01, "gap_b");
        check("gap_cnt", det_count, 8'd1);

        // Illegal lengths leave configuration untouched
        load_cfg(8'b0000_0011, 4'd1, 1'b1, 1'b1, "bad1");
        load_cfg(8'b0000_0011, 4'd0, 1'b1, 1'b1, "bad0");
        load_cfg(8'b0000_0011, 4'd9, 1'b1, 1'b1, "bad9");
        check("bad_cnt_kept", det_count, 8'd1);
        send_stream(16'b11_1010, 6, 16'b00_0001, "bad_old");
        check("bad_old_cnt", det_count, 8'd2);

        // Pattern 11 overlapping; 2-bit counter saturates
        load_cfg(8'b0000_0011, 4'd2, 1'b1, 1'b0, "ld11");
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_seq   = 1'b1;
            #4;
            check($sformatf("p11_b%0d", i), det_out, (i >= 2));
            check($sformatf("p11s_b%0d", i), det_out2, (i >= 2));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("p11_cnt", det_count, 8'd7);
        check("p11_sat", det_count2, 2'd3);

        // Asynchronous reset mid-pattern
        load_cfg(8'b0011_1010, 4'd6, 1'b0, 1'b0, "ldrst");
        send_stream(16'b11_1010, 6, 16'b00_0001, "pre_rst");
        check("pre_rst_cnt", det_count, 8'd1);
        send_stream(16'b1_1101, 5, 16'b0_0000, "part");
        #2 rst = 1'b1;
        #1;
        check("arst_cnt", det_count, 8'd0);
        check("arst_det", det_out, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_stream(16'b0, 1, 16'b0, "post_rst0");
        send_stream(16'b11_1010, 6, 16'b00_0001, "post_rst");
        check("post_rst_cnt", det_count, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Parametrised, run-time programmable Mealy serial-pattern detector. It is the successor to the fixed-pattern, fixed-length detectors in the sequence-detector library. The pattern (up to MAX_LEN bits), its length and the overlap mode are loaded through a config port. Detections are reported combinationally on the matching input bit and counted in a saturating counter.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: detection counter width
- RST_PAT, 8'b0011_1010: pattern after reset, right-aligned (legacy 111010)
- RST_LEN, 6: pattern length after reset
- RST_OVL, 1'b0: overlap mode after reset (0 = non-overlapping)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  qualifies in_seq; history advances only when high
- in_seq  input  1  serial data bit
- cfg_load  input  1  one-cycle strobe; loads cfg_* fields
- cfg_pat  input  MAX_LEN  pattern, right-aligned; bit cfg_len-1 is received first
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length, legal range 2..MAX_LEN
- cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
- det_out  output  1  Mealy detect: high in the cycle the final pattern bit is presented
- det_count  output  CNT_W  saturating count of detections
- cfg_err  output  1  registered one-cycle pulse: cfg_load carried an illegal cfg_len

## Operation
- State registers:
  - hist[MAX_LEN-2:0]: received bits, newest in bit 0
  - fill: count of valid history bits, saturating at MAX_LEN-1
  - pat, len, ovl: active configuration
  - det_count
- Reset values:
  - hist = 0, fill = 0, det_count = 0, cfg_err = 0
  - pat/len/ovl = RST_PAT/RST_LEN/RST_OVL
  - det_out = 0 (in_valid low)
- Match (combinational): in_valid && fill ≥ len-1 && {hist[len-2:0], in_seq} == pat[len-1:0]. det_out equals this match term and depends on the current in_seq.
- On a clock edge with in_valid high and no match:
  - hist ← {hist, in_seq}
  - fill ← min(fill+1, MAX_LEN-1)
- On a clock edge with in_valid high and a match:
  - det_count ← det_count+1, holding at all-ones once saturated.
  - ovl=1: history shifts exactly as in the no-match case, so suffix bits can begin the next match.
  - ovl=0: hist ← 0 and fill ← 0. The next match needs len fresh bits.
- in_valid low: hist, fill and det_count hold; det_out = 0.
- cfg_load with 2 ≤ cfg_len ≤ MAX_LEN:
  - pat/len/ovl take the new values.
  - hist and fill clear to 0; det_count clears to 0.
  - in_seq in the same cycle is ignored: no shift, and det_out is forced 0.
- cfg_load with an illegal cfg_len:
  - Configuration and state are unchanged.
  - cfg_err pulses for one cycle. The same-cycle input is still ignored.
- pat bits above len-1 are don't-care.

## Timing
- det_out: zero latency, combinational from in_valid, in_seq and registered state.
- New configuration applies from the first in_valid cycle after the cfg_load edge.
- cfg_err is asserted in the cycle after cfg_load.
- Asynchronous rst clears immediately, mid-pattern included. Detection resumes len valid bits after rst deasserts.
- Simultaneous match and saturated det_count: det_out still pulses, det_count holds at all-ones.

## Structure
- Shared package seq_det_pkg holds:
  - localparam LEN_W = $clog2(MAX_LEN+1)
  - a function len_legal(len, max) used by this block and by the bench
- One sub-module, seq_det_sat_cnt: generic saturating counter with clear and increment. Its widths come from CNT_W.
- Everything else stays in the top module: history shifter, fill counter, config registers, match logic.

## Test plan
- Reset defaults, ovl=0, stream 111010111010 (all in_valid) → det_out high on bit 6 and bit 12 only; det_count=2.
- Load pat=1010, len=4, ovl=1; stream 1010101 → det_out high on bits 4 and 6; det_count=2. Same stream with ovl=0 → one detection, at bit 4.
- Stream 1110 + in_valid low for 3 cycles with in_seq toggling + 10 → single detection on the final bit; det_count=1.
- cfg_load with cfg_len=1, then 0, then MAX_LEN+1 → cfg_err pulses one cycle each; the previous pattern still detects.
- CNT_W=2, ovl=1, pattern 11, stream of eight 1s → det_out high on bits 2–8; det_count saturates at 3.
- Assert rst asynchronously after 11101 → det_count=0 immediately; trailing 0 gives no detection; a full 111010 afterwards detects.
